// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: cause code, FSM encoding
// and the registered control bundle.
package ex_mem_stage_pkg;

  localparam logic [4:0] EXC_OV_CODE = 5'd12;
  localparam int         CTRL_W      = 3;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  // Drop every control bit of a bundle that does not belong to a real instruction.
  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic v);
    return ctrl_t'({CTRL_W{v}} & c);
  endfunction

endpackage

// File: rtl/ex_mem_stage_branch_resolve.sv
// Combinational branch resolution: taken decision and PC-relative target.
// Kept separate so it can be reused if branch resolution moves to decode.
module ex_mem_stage_branch_resolve
  import ex_mem_stage_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         i_valid,
  input  logic         i_branch,
  input  logic         i_cond,
  input  logic [N-1:0] i_pc_plus4,
  input  logic [N-1:0] i_offset,
  output logic         o_taken,
  output logic [N-1:0] o_target
);

  assign o_taken  = i_valid & i_branch & i_cond;
  // Word offset scaled to bytes; the sum wraps modulo 2^N.
  assign o_target = i_pc_plus4 + {i_offset[N-3:0], 2'b00};

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution and precise overflow trap.
// Overflow trapping is built only when EXMEM_OVF_TRAP_EN is defined.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int         N      = 32,
  parameter int         RW     = 5,
  parameter logic [4:0] EXC_OV = EXC_OV_CODE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [N-1:0]  pc_plus4,
  input  logic [N-1:0]  alu_out,
  input  logic          alu_zero,
  input  logic          alu_overflow,
  input  logic          trap_en,
  input  logic [N-1:0]  store_data,
  input  logic [RW-1:0] rd,
  input  logic          reg_write,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic          branch,
  input  logic [N-1:0]  br_offset,
  input  logic          exc_ack,
  output logic          out_valid,
  output logic [N-1:0]  out_alu,
  output logic [N-1:0]  out_store_data,
  output logic [RW-1:0] out_rd,
  output logic          out_reg_write,
  output logic          out_mem_read,
  output logic          out_mem_write,
  output logic          br_taken,
  output logic [N-1:0]  br_target,
  output logic          exc_valid,
  output logic [N-1:0]  epc,
  output logic [4:0]    exc_cause
);

  logic          w_br_taken;
  logic [N-1:0]  w_br_target;
  logic          w_do_bubble;
  logic          w_do_capture;
  ctrl_t         w_ctrl_raw;
  ctrl_t         w_ctrl_in;

  logic          r_valid;
  ctrl_t         r_ctrl;
  logic          r_br_taken;
  logic [N-1:0]  r_alu;
  logic [N-1:0]  r_store_data;
  logic [RW-1:0] r_rd;
  logic [N-1:0]  r_br_target;

  ex_mem_stage_branch_resolve #(.N(N)) u_branch_resolve (
    .i_valid    (in_valid),
    .i_branch   (branch),
    .i_cond     (alu_zero),
    .i_pc_plus4 (pc_plus4),
    .i_offset   (br_offset),
    .o_taken    (w_br_taken),
    .o_target   (w_br_target)
  );

  assign w_ctrl_raw = {reg_write, mem_read, mem_write};
  assign w_ctrl_in  = gate_ctrl(w_ctrl_raw, in_valid);

`ifdef EXMEM_OVF_TRAP_EN
  state_e       r_state;
  state_e       w_nxt_state;
  logic         w_ovf;
  logic         w_raise;
  logic         w_clear;
  logic         r_exc_valid;
  logic [N-1:0] r_epc;
  logic [4:0]   r_exc_cause;

  assign w_ovf = in_valid & trap_en & alu_overflow;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Next state and per-edge stage action; exception beats branch, flush beats stall
  always_comb begin
    w_nxt_state  = r_state;
    w_do_bubble  = 1'b0;
    w_do_capture = 1'b0;
    w_raise      = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (flush) begin
          w_do_bubble = 1'b1;
        end else if (stall) begin
          w_do_capture = 1'b0;
        end else if (w_ovf) begin
          w_do_bubble = 1'b1;
          w_raise     = 1'b1;
          w_nxt_state = ST_TRAP;
        end else begin
          w_do_capture = 1'b1;
        end
      end
      ST_TRAP: begin
        w_do_bubble = 1'b1;
        if (exc_ack) begin
          w_clear     = 1'b1;
          w_nxt_state = ST_RUN;
        end else begin
          w_nxt_state = ST_TRAP;
        end
      end
      default: begin
        w_do_bubble = 1'b1;
        w_nxt_state = ST_RUN;
      end
    endcase
  end

  // Sticky exception record; epc is the faulting instruction's own address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exc_valid <= 1'b0;
      r_epc       <= {N{1'b0}};
      r_exc_cause <= 5'd0;
    end else if (w_raise) begin
      r_exc_valid <= 1'b1;
      r_epc       <= pc_plus4 - {{(N-3){1'b0}}, 3'd4};
      r_exc_cause <= EXC_OV;
    end else if (w_clear) begin
      r_exc_valid <= 1'b0;
      r_exc_cause <= 5'd0;
    end else begin
      r_exc_valid <= r_exc_valid;
    end
  end

  assign exc_valid = r_exc_valid;
  assign epc       = r_epc;
  assign exc_cause = r_exc_cause;
`else
  logic w_unused;
  assign w_unused = ^{exc_ack, trap_en, alu_overflow};

  // Without trapping the stage only flushes, holds or captures
  always_comb begin
    w_do_bubble  = 1'b0;
    w_do_capture = 1'b0;
    if (flush) begin
      w_do_bubble = 1'b1;
    end else if (stall) begin
      w_do_capture = 1'b0;
    end else begin
      w_do_capture = 1'b1;
    end
  end

  assign exc_valid = 1'b0;
  assign epc       = {N{1'b0}};
  assign exc_cause = 5'd0;
`endif

  // Stage registers; the redirect pulse is dropped on any non-capturing edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_ctrl       <= {CTRL_W{1'b0}};
      r_br_taken   <= 1'b0;
      r_alu        <= {N{1'b0}};
      r_store_data <= {N{1'b0}};
      r_rd         <= {RW{1'b0}};
      r_br_target  <= {N{1'b0}};
    end else if (w_do_bubble) begin
      r_valid    <= 1'b0;
      r_ctrl     <= {CTRL_W{1'b0}};
      r_br_taken <= 1'b0;
    end else if (w_do_capture) begin
      r_valid      <= in_valid;
      r_ctrl       <= w_ctrl_in;
      r_br_taken   <= w_br_taken;
      r_alu        <= alu_out;
      r_store_data <= store_data;
      r_rd         <= rd;
      r_br_target  <= w_br_target;
    end else begin
      r_br_taken <= 1'b0;
    end
  end

  assign out_valid      = r_valid;
  assign out_alu        = r_alu;
  assign out_store_data = r_store_data;
  assign out_rd         = r_rd;
  assign out_reg_write  = r_ctrl.reg_write;
  assign out_mem_read   = r_ctrl.mem_read;
  assign out_mem_write  = r_ctrl.mem_write;
  assign br_taken       = r_br_taken;
  assign br_target      = r_br_target;

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline register and resolution logic directly downstream of the execute-stage ALU.
- Captures the ALU result and flags plus the control bits carried from decode.
- Resolves conditional branches from the ALU zero flag and raises a precise overflow exception.
- Feeds the memory stage; redirects/flushes the front end.

Parameters:
N, 32, datapath width (ALU result, PC, store data)
RW, 5, register-index width
EXC_OV, 5'd12, cause code reported for arithmetic overflow

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold all stage registers (memory stage busy)
flush  in  1  insert bubble at next capture
in_valid  in  1  execute stage holds a real instruction
pc_plus4  in  N  PC+4 of the executing instruction
alu_out  in  N  ALU result
alu_zero  in  1  ALU zero flag (BEQ/BNE both encode "condition met" as 1)
alu_overflow  in  1  ALU overflow flag
trap_en  in  1  instruction is a trapping signed op (add/sub/mul/div)
store_data  in  N  rt value for stores
rd  in  RW  destination register
reg_write, mem_read, mem_write, branch  in  1 each  decode control bits
br_offset  in  N  sign-extended immediate (word offset)
exc_ack  in  1  exception handler has taken the exception
out_valid  out  1  memory stage holds a real instruction
out_alu, out_store_data  out  N each  registered alu_out / store_data
out_rd  out  RW  registered rd
out_reg_write, out_mem_read, out_mem_write  out  1 each  registered control, gated
br_taken  out  1  one-cycle redirect pulse
br_target  out  N  pc_plus4 + (br_offset << 2), registered
exc_valid  out  1  exception pending (sticky)
epc  out  N  address of faulting instruction (pc_plus4 - 4)
exc_cause  out  5  EXC_OV when exc_valid

Behaviour:
- Reset (async, rst_n=0): every output 0; state RUN. Takes effect mid-operation regardless of stall/trap.
- Latency: one cycle from execute inputs to all outputs.
- FSM states: RUN, TRAP.
  - RUN: see per-edge capture rules below.
  - TRAP: stage outputs are bubbles (out_valid=0, controls 0); inputs ignored; exc_valid/epc/exc_cause held. exc_ack=1 -> RUN next edge with exc_valid cleared. stall does not block exc_ack.
- RUN, each edge, priority order:
  - flush=1 (wins over stall): bubble (out_valid, out_reg_write, out_mem_*, br_taken = 0; data regs may hold).
  - stall=1: all regs hold, except br_taken cleared (pulse never repeats).
  - Else capture. ovf = in_valid & trap_en & alu_overflow.
    - ovf=1: bubble, exc_valid=1, epc=pc_plus4-4, exc_cause=EXC_OV, go TRAP. Exception beats branch.
    - Else: out_valid=in_valid; controls = inputs AND in_valid; br_taken = in_valid & branch & alu_zero; br_target always computed.
- Arithmetic: br_target and epc in N-bit modulo; wrap-around at 2^N silently, no flag.
- exc_ack while in RUN is ignored.
- br_taken and exc_valid never both rise on the same edge.

Optional Feature:
- Macro EXMEM_OVF_TRAP_EN.
- Defined: overflow trapping exactly as above.
- Undefined:
  - No TRAP state; exc_valid, epc, exc_cause tied 0.
  - Overflowing instruction completes normally with wrapped result and writeback.
  - exc_ack and trap_en unused.

Decomposition:
- Shared defines file: EXC_OV cause code, FSM state encodings (RUN=1'b0, TRAP=1'b1), control-bundle width.
- One sub-module natural: branch_resolve (combinational taken/target computation, reusable if branches move to decode).

Test Plan:
- Reset mid-TRAP: assert rst_n=0 while exc_valid=1 -> all outputs 0 immediately, state RUN after release.
- ADD: alu_out=32'h0000_0005, rd=3, reg_write=1, in_valid=1 -> next cycle out_valid=1, out_alu=5, out_rd=3, out_reg_write=1.
- BEQ taken: pc_plus4=32'h0000_0100, br_offset=32'hFFFF_FFFC, alu_zero=1, branch=1 -> br_taken=1 for exactly one cycle, br_target=32'h0000_00F0. Repeat with stall=1 the next cycle -> br_taken=0.
- Overflow trap: pc_plus4=32'h0000_2004, trap_en=1, alu_overflow=1 -> exc_valid=1, epc=32'h0000_2000, exc_cause=12, out_reg_write=0. New inputs ignored. exc_ack=1 -> exc_valid=0 next edge, capture resumes.
- Overflow with trap_en=0 (addu): out_reg_write=1, exc_valid stays 0.
- flush=1 and stall=1 together with valid store input -> out_valid=0, out_mem_write=0. With macro undefined, overflow case from scenario 4 -> out_reg_write=1, exc_valid=0.
